// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI slave command sequencer driving a single-cycle register bus
module spi_reg_ctrl #(
  parameter int          ADDR_W      = 7,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ss,
  input  logic              done,
  input  logic [7:0]        rdata,
  output logic [7:0]        tdata,
  output logic              ten,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              txn_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_DATA, RD_FETCH, RD_CAP, RD_DATA
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [SYNC_STAGES-1:0] ss_sync_q, done_sync_q;
  logic                   ss_prev_q, done_prev_q;
  // Marks when ss_s and ss_prev_q both hold real samples taken after reset,
  // so a frame already running at reset release never looks like a fresh ss_fall.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   ss_s, done_s, sync_ok;
  logic                   byte_vld, ss_fall, ss_rise;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tdata_q, tdata_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              txn_done_q, txn_done_d;
  logic              ten_q;

  // Synchronize ss/done into clk and keep previous samples for edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ss_sync_q   <= '1;
      done_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      done_prev_q <= 1'b0;
      fill_q      <= '0;
      ten_q       <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], done};
      ss_prev_q   <= ss_s;
      done_prev_q <= done_s;
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      ten_q       <= ~ss_s;
    end
  end

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign done_s   = done_sync_q[SYNC_STAGES-1];
  assign sync_ok  = fill_q[SYNC_STAGES];
  assign byte_vld = done_s & ~done_prev_q;
  assign ss_fall  = sync_ok & ss_prev_q & ~ss_s;
  assign ss_rise  = sync_ok & ~ss_prev_q & ss_s;

  // State and output registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      tdata_q     <= IDLE_BYTE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      txn_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tdata_q     <= tdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      txn_done_q  <= txn_done_d;
    end
  end

  // Next-state: process any received byte first, then let ss_rise close the frame
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tdata_d     = tdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    txn_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = CMD;
          tdata_d = IDLE_BYTE;
        end
      end
      CMD: begin
        if (byte_vld) begin
          addr_d = rdata[ADDR_W-1:0];
          if (rdata[7]) begin
            // reg_rd is registered, so it is high for the whole RD_FETCH clk
            state_d    = RD_FETCH;
            reg_rd_d   = 1'b1;
            reg_addr_d = rdata[ADDR_W-1:0];
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (byte_vld) begin
          reg_wr_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = rdata;
          addr_d      = addr_q + ADDR_ONE;
        end
      end
      RD_FETCH: state_d = RD_CAP;
      RD_CAP: begin
        // reg_rdata is valid here, one clk after the reg_rd strobe
        tdata_d = reg_rdata;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (byte_vld) begin
          addr_d     = addr_q + ADDR_ONE;
          state_d    = RD_FETCH;
          reg_rd_d   = 1'b1;
          reg_addr_d = addr_q + ADDR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ss_rise && (state_q != IDLE)) begin
      state_d    = IDLE;
      tdata_d    = IDLE_BYTE;
      txn_done_d = (state_q != CMD) || byte_vld;
    end
  end

  assign tdata     = tdata_q;
  assign ten       = ten_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign txn_done  = txn_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ss;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] tdata;
  logic       ten;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       txn_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:127];
  logic [14:0] wr_q [$];
  logic [6:0]  rd_q [$];
  logic [7:0]  miso_q [$];
  int          txn_cnt = 0;

  spi_reg_ctrl #(.ADDR_W(7), .SYNC_STAGES(2), .IDLE_BYTE(8'hA5)) dut (
    .clk(clk), .rstb(rstb), .ss(ss), .done(done), .rdata(rdata),
    .tdata(tdata), .ten(ten), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .txn_done(txn_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bus: read data returned one clk after reg_rd
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  // Strobe logger, sampled on the falling edge
  always @(negedge clk) begin
    if (reg_wr)   wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd)   rd_q.push_back(reg_addr);
    if (txn_done) txn_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    miso_q.delete();
    txn_cnt = 0;
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ss = 1'b0;
    clks(4);
  endtask

  task automatic frame_end();
    ss = 1'b1;
    clks(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    miso_q.push_back(tdata);
    rdata = b;
    clks(4);
    done = 1'b1;
    clks(4);
    done = 1'b0;
    clks(6);
  endtask

  initial begin
    rstb = 1'b0; ss = 1'b1; done = 1'b0; rdata = 8'h00; reg_rdata = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'hC3;
    mem[7'h11] = 8'h3C;
    mem[7'h12] = 8'h77;
    clks(3);

    chk("rst_tdata", tdata, 8'hA5);
    chk("rst_ten", ten, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_txn_done", txn_done, 0);
    chk("rst_busy", busy, 0);

    rstb = 1'b1;
    clks(6);

    // Write burst starting at 0x05
    clear_logs();
    frame_begin();
    chk("wr_busy_in_frame", busy, 1);
    chk("wr_ten_in_frame", ten, 1);
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    frame_end();
    chk("wr_count", wr_q.size(), 3);
    chk("wr0", wr_q[0], {7'h05, 8'h11});
    chk("wr1", wr_q[1], {7'h06, 8'h22});
    chk("wr2", wr_q[2], {7'h07, 8'h33});
    chk("wr_no_rd", rd_q.size(), 0);
    chk("wr_txn_done", txn_cnt, 1);
    chk("wr_busy_after", busy, 0);
    chk("wr_ten_after", ten, 0);

    // Read burst from 0x10 with two dummy bytes
    clear_logs();
    frame_begin();
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h00);
    frame_end();
    chk("rd_miso0", miso_q[0], 8'hA5);
    chk("rd_miso1", miso_q[1], 8'hC3);
    chk("rd_miso2", miso_q[2], 8'h3C);
    chk("rd_count", rd_q.size(), 3);
    chk("rd0", rd_q[0], 7'h10);
    chk("rd1", rd_q[1], 7'h11);
    chk("rd2", rd_q[2], 7'h12);
    chk("rd_no_wr", wr_q.size(), 0);
    chk("rd_txn_done", txn_cnt, 1);
    chk("rd_tdata_idle", tdata, 8'hA5);

    // Address wrap 0x7F -> 0x00
    clear_logs();
    frame_begin();
    send_byte(8'h7F); send_byte(8'hAA); send_byte(8'hBB);
    frame_end();
    chk("wrap_count", wr_q.size(), 2);
    chk("wrap0", wr_q[0], {7'h7F, 8'hAA});
    chk("wrap1", wr_q[1], {7'h00, 8'hBB});

    // Abort after 4 bits of the first data byte
    clear_logs();
    frame_begin();
    send_byte(8'h20);
    rdata = 8'hEE;
    clks(4);
    frame_end();
    chk("abort_no_wr", wr_q.size(), 0);
    chk("abort_txn_done", txn_cnt, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tdata", tdata, 8'hA5);

    // Reset during RD_DATA
    clear_logs();
    frame_begin();
    send_byte(8'h90); send_byte(8'h00);
    chk("rst_mid_pre_tdata", tdata, 8'h3C);
    chk("rst_mid_pre_busy", busy, 1);
    #2 rstb = 1'b0;
    #1;
    chk("rst_mid_tdata", tdata, 8'hA5);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ten", ten, 0);
    chk("rst_mid_reg_addr", reg_addr, 0);
    chk("rst_mid_reg_rd", reg_rd, 0);
    @(negedge clk);
    rstb = 1'b1;
    clear_logs();
    clks(6);
    chk("rst_mid_ignored_busy", busy, 0);
    send_byte(8'h00);
    send_byte(8'h05);
    frame_end();
    chk("rst_mid_no_rd", rd_q.size(), 0);
    chk("rst_mid_no_wr", wr_q.size(), 0);
    chk("rst_mid_no_txn", txn_cnt, 0);

    // Fresh frame after the reset works again
    clear_logs();
    frame_begin();
    send_byte(8'h30); send_byte(8'h99);
    frame_end();
    chk("post_rst_wr_count", wr_q.size(), 1);
    chk("post_rst_wr0", wr_q[0], {7'h30, 8'h99});

    // Same-clk byte_vld and ss_rise in WR_DATA
    clear_logs();
    frame_begin();
    send_byte(8'h40);
    rdata = 8'h5A;
    clks(4);
    done = 1'b1;
    ss   = 1'b1;
    clks(4);
    done = 1'b0;
    clks(8);
    chk("same_wr_count", wr_q.size(), 1);
    chk("same_wr0", wr_q[0], {7'h40, 8'h5A});
    chk("same_txn_done", txn_cnt, 1);
    chk("same_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
